// File: rtl/ex_mem_pkg.sv
// Shared constants and payload layout for the EX->MEM stage register.
// Control bundle bit positions are fixed; bits above CTRL_MEM_W are user-defined.
package ex_mem_pkg;

   localparam int CTRL_REG_W     = 0;
   localparam int CTRL_MEM_TO_REG = 1;
   localparam int CTRL_MEM_W     = 2;

   function automatic int pay_w(input int dw, input int aw, input int cw);
      return cw + 3 * dw + aw;
   endfunction

   typedef struct packed {
      logic [2:0]  ctrl;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [4:0]  rd;
      logic [31:0] inst;
   } ex_mem_pay_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with flush; EX_MEM_SKID_EN adds a
// one-entry skid register so in_ready no longer depends on out_ready.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         r_vld_p1;
   logic [W-1:0] r_dat_p1;
   logic         w_consume;
   logic         w_accept;

   assign w_consume = r_vld_p1 & out_ready;
   assign w_accept  = in_valid & in_ready & ~flush;
   assign out_valid = r_vld_p1;
   assign out_data  = r_dat_p1;

`ifdef EX_MEM_SKID_EN
   logic         r_skid_vld_p1;
   logic [W-1:0] r_skid_dat_p1;

   assign in_ready = ~r_skid_vld_p1;

   // Skid only fills while main is full and stalled, so main is never empty with skid full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1      <= 1'b0;
         r_dat_p1      <= '0;
         r_skid_vld_p1 <= 1'b0;
         r_skid_dat_p1 <= '0;
      end else if (flush) begin
         r_vld_p1      <= 1'b0;
         r_skid_vld_p1 <= 1'b0;
      end else if (!r_vld_p1 || w_consume) begin
         if (r_skid_vld_p1) begin
            r_vld_p1      <= 1'b1;
            r_dat_p1      <= r_skid_dat_p1;
            r_skid_vld_p1 <= w_accept;
            if (w_accept) r_skid_dat_p1 <= in_data;
         end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) r_dat_p1 <= in_data;
         end
      end else if (w_accept) begin
         r_skid_vld_p1 <= 1'b1;
         r_skid_dat_p1 <= in_data;
      end
   end
`else
   assign in_ready = out_ready | ~r_vld_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_dat_p1 <= '0;
      end else if (flush) begin
         r_vld_p1 <= 1'b0;
      end else if (in_ready) begin
         r_vld_p1 <= in_valid;
         if (in_valid) r_dat_p1 <= in_data;
      end
   end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: packs fields into pipe_skid_buf, gates ctrl to NOP
// on bubbles and exposes a registered forwarding tap. Option: EX_MEM_SKID_EN.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0] in_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_rt,
   output logic [ADDR_W-1:0] out_rd,
   output logic [DATA_W-1:0] out_inst,
   output logic              fwd_en,
   output logic [ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0] fwd_data
);

   localparam int PW = pay_w(DATA_W, ADDR_W, CTRL_W);

   logic [PW-1:0]     w_in_pay;
   logic [PW-1:0]     w_out_pay;
   logic [CTRL_W-1:0] w_ctrl;
   logic              w_out_valid;

   assign w_in_pay = {in_ctrl, in_alu, in_rt, in_rd, in_inst};

   pipe_skid_buf #(.W(PW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_in_pay),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .out_data  (w_out_pay)
   );

   assign {w_ctrl, out_alu, out_rt, out_rd, out_inst} = w_out_pay;

   // Data fields keep their stale value on a bubble; only ctrl is squashed.
   assign out_valid = w_out_valid;
   assign out_ctrl  = w_out_valid ? w_ctrl : '0;
   assign fwd_en    = w_out_valid & w_ctrl[CTRL_REG_W] & (out_rd != '0);
   assign fwd_rd    = out_rd;
   assign fwd_data  = out_alu;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage; the reference model tracks held beats as a
// FIFO of capacity 1 (or 2 with EX_MEM_SKID_EN) and derives ready/valid from it.
module tb_ex_mem_stage;
   import ex_mem_pkg::*;

`ifdef EX_MEM_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_ctrl;
   logic [31:0] in_alu;
   logic [31:0] in_rt;
   logic [4:0]  in_rd;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ctrl;
   logic [31:0] out_alu;
   logic [31:0] out_rt;
   logic [4:0]  out_rd;
   logic [31:0] out_inst;
   logic        fwd_en;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   ex_mem_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_alu    (in_alu),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_alu   (out_alu),
      .out_rt    (out_rt),
      .out_rd    (out_rd),
      .out_inst  (out_inst),
      .fwd_en    (fwd_en),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   ex_mem_pay_t sb[$];
   logic        exp_ready = 1'b1;
   logic        mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ex_mem_pay_t rand_beat();
      ex_mem_pay_t b;
      b.ctrl = 3'($urandom_range(0, 7));
      b.alu  = $urandom;
      b.rt   = $urandom;
      b.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b.inst = $urandom;
      return b;
   endfunction

   function automatic ex_mem_pay_t mk_beat(input logic [2:0] c, input logic [31:0] a, input logic [4:0] r);
      ex_mem_pay_t b;
      b.ctrl = c;
      b.alu  = a;
      b.rt   = $urandom;
      b.rd   = r;
      b.inst = $urandom;
      return b;
   endfunction

   // One cycle of stimulus; the beat enters the model when the model says it is taken.
   task automatic drive(input logic v, input ex_mem_pay_t b, input logic ordy, input logic fl);
      logic acc;
      @(negedge clk);
      in_valid  = v;
      in_ctrl   = b.ctrl;
      in_alu    = b.alu;
      in_rt     = b.rt;
      in_rd     = b.rd;
      in_inst   = b.inst;
      out_ready = ordy;
      flush     = fl;
      if (CAP == 2) exp_ready = (sb.size() < 2);
      else          exp_ready = (sb.size() == 0) || ordy;
      acc = v && exp_ready && !fl;
      @(posedge clk);
      if (acc) sb.push_back(b);
   endtask

   // Monitor: compares every visible output against the head of the scoreboard.
   initial begin
      ex_mem_pay_t f;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
            if (sb.size() > 0) begin
               f = sb[0];
               check("out_ctrl", 32'(out_ctrl), 32'(f.ctrl));
               check("out_alu", out_alu, f.alu);
               check("out_rt", out_rt, f.rt);
               check("out_rd", 32'(out_rd), 32'(f.rd));
               check("out_inst", out_inst, f.inst);
               check("fwd_en", 32'(fwd_en), 32'(f.ctrl[CTRL_REG_W] && (f.rd != 5'd0)));
               check("fwd_rd", 32'(fwd_rd), 32'(f.rd));
               check("fwd_data", fwd_data, f.alu);
               if (out_ready) void'(sb.pop_front());
            end else begin
               check("bubble_ctrl", 32'(out_ctrl), 32'd0);
               check("bubble_fwd_en", 32'(fwd_en), 32'd0);
            end
            if (flush) sb.delete();
         end
      end
   end

   initial begin
      ex_mem_pay_t idle;
      idle = '0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_alu = '0; in_rt = '0; in_rd = '0; in_inst = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
      check("rst_out_alu", out_alu, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
      check("rst_fwd_en", 32'(fwd_en), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ready = 1'b1;
      mon_en = 1'b1;

      // Single beat with forwarding, then bubbles.
      drive(1'b1, mk_beat(3'b001, 32'h0000_1234, 5'd7), 1'b1, 1'b0);
      repeat (2) drive(1'b0, idle, 1'b1, 1'b0);

      // Back-to-back stream.
      for (int i = 0; i < 8; i++) drive(1'b1, rand_beat(), 1'b1, 1'b0);
      repeat (2) drive(1'b0, idle, 1'b1, 1'b0);

      // Stall with input pressure, then release.
      for (int i = 0; i < 3; i++) drive(1'b1, rand_beat(), 1'b0, 1'b0);
      repeat (4) drive(1'b0, idle, 1'b1, 1'b0);

      // Flush with the stage full and a beat presented.
      for (int i = 0; i < 3; i++) drive(1'b1, rand_beat(), 1'b0, 1'b0);
      drive(1'b1, rand_beat(), 1'b0, 1'b1);
      repeat (3) drive(1'b0, idle, 1'b1, 1'b0);

      // Flush while the head is consumed.
      for (int i = 0; i < 2; i++) drive(1'b1, rand_beat(), 1'b0, 1'b0);
      drive(1'b1, rand_beat(), 1'b1, 1'b1);
      drive(1'b0, idle, 1'b1, 1'b0);

      // Forwarding guards: rd=0 with reg_w, and a store.
      drive(1'b1, mk_beat(3'b001, 32'hdead_0001, 5'd0), 1'b1, 1'b0);
      drive(1'b1, mk_beat(3'b100, 32'hdead_0002, 5'd5), 1'b1, 1'b0);
      drive(1'b1, mk_beat(3'b011, 32'hdead_0003, 5'd31), 1'b1, 1'b0);
      repeat (2) drive(1'b0, idle, 1'b1, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0);
      repeat (4) drive(1'b0, idle, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a stall.
      for (int i = 0; i < 2; i++) drive(1'b1, rand_beat(), 1'b0, 1'b0);
      @(negedge clk);
      mon_en = 1'b0;
      in_valid = 1'b0;
      #1;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_ctrl", 32'(out_ctrl), 32'd0);
      check("async_rst_alu", out_alu, 32'd0);
      check("async_rst_fwd_en", 32'(fwd_en), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exp_ready = 1'b1;
      mon_en = 1'b1;
      drive(1'b1, mk_beat(3'b001, 32'h0000_5678, 5'd9), 1'b1, 1'b0);
      repeat (2) drive(1'b0, idle, 1'b1, 1'b0);

      @(negedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
